exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception sequencer between the CPU execute stage and the CP0 register file. Detects syscall/break/teq/eret in the executing instruction and gates trap entry with the CP0 Status mask. Issues a one-cycle exception or eret command to CP0, waits for CP0's negedge update, then redirects the PC to CP0's `exc_addr` while stalling and flushing the CPU. Also forwards mtc0/mfc0 accesses to CP0 and keeps them off the CP0 port while a trap is being sequenced.

## Interface
Parameters:
- `VEC_ADDR`, 32'h00400004: expected trap vector; compared against `exc_addr` only for the `vec_err` flag.
- `CNT_W`, 8: width of the taken-exception counter.

Ports:
- `clk`  in  1  system clock; all state on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  executing instruction is valid.
- `pc_in`  in  32  PC of the executing instruction.
- `is_syscall`, `is_break`, `is_teq`, `is_eret`  in  1 each  decoded class.
- `teq_equal`  in  1  rs==rt for teq.
- `is_mtc0`, `is_mfc0`  in  1 each  CP0 move decode.
- `rd_in`  in  5  CP0 register index.
- `status_in`  in  32  CP0 Status.
- `exc_addr_in`  in  32  CP0 exc_addr.
- `cp0_exception`, `cp0_eret`  out  1 each  CP0 command strobes.
- `cp0_cause`  out  5  8 = syscall, 9 = break, 13 = teq; 0 otherwise.
- `cp0_pc`  out  32  PC latched at detection.
- `cp0_mtc0`, `cp0_mfc0`  out  1 each  forwarded moves.
- `cp0_rd`  out  5  forwarded index.
- `stall`  out  1  freeze CPU PC/pipeline.
- `flush`, `pc_redirect`  out  1 each  redirect strobes.
- `redirect_pc`  out  32  new PC.
- `busy`  out  1  FSM not in IDLE.
- `exc_count`  out  CNT_W  taken traps, saturating.
- `vec_err`  out  1  sticky: trap entry redirected to an address other than `VEC_ADDR`.

## Operation
- States: IDLE, ISSUE, WAIT, REDIRECT.
- IDLE: a trap is detected when `instr_valid` is set and `is_mtc0` is clear. Detection priority is eret > break > syscall > (teq & `teq_equal`).
- Masking, non-eret only: the trap is taken only if `status_in[0]` is set and the matching IM bit is set (syscall bit 8, break bit 9, teq bit 10). A masked trap is ignored: no state change, no count.
- On a taken event: latch `pc_in` into `cp0_pc`, latch the cause and an eret flag, then go to ISSUE.
- ISSUE: assert `cp0_exception`=1 for exactly one cycle, and `cp0_eret` only for eret. CP0 updates on the following negedge. Next state WAIT.
- WAIT: capture `exc_addr_in` into `redirect_pc`. Next state REDIRECT.
- REDIRECT: `pc_redirect`=1 and `flush`=1 for one cycle. Next state IDLE.
- On leaving ISSUE for a non-eret trap, `exc_count` increments and saturates at 2^CNT_W−1.
- `vec_err` is set in REDIRECT when a non-eret trap has `redirect_pc` != `VEC_ADDR`. It is cleared only by reset.
- mtc0/mfc0 forwarding: `cp0_mtc0` = `is_mtc0 & instr_valid & IDLE`, `cp0_mfc0` = `is_mfc0 & IDLE`, `cp0_rd` = `rd_in`. All are combinational and forced to 0 outside IDLE.
- `is_mtc0` together with any trap flag: mtc0 is forwarded and the trap flags are ignored.
- Nesting: CP0 shifts Status left 5 on trap entry, which clears bit 0. Further syscall/break/teq are then masked until eret. Eret is never masked.

## Timing
- Reset values: state IDLE; all strobes 0; `cp0_cause`=0; `cp0_pc`=0; `redirect_pc`=0; `exc_count`=0; `vec_err`=0; `busy`=0; `stall`=0.
- `stall`=`busy`, high in ISSUE, WAIT and REDIRECT. It is low in the detection cycle; the trapping instruction is frozen from the next edge.
- Latency: detection edge T → ISSUE in cycle T+1 → WAIT in T+2 → REDIRECT in T+3 → IDLE at T+4. The earliest next detection is in cycle T+4.
- `cp0_pc` and `cp0_cause` are held stable from ISSUE until the next detection.
- `exc_addr_in` must be sampled only in WAIT; in ISSUE it is stale.
- Reset asserted in any state returns to IDLE at that edge, with no partial strobe afterwards.
- `instr_valid` is ignored outside IDLE.

## Test plan
- Reset, Status=0x701, then syscall at pc 0x00400100:
  - `cp0_exception` high 1 cycle with `cp0_cause`=8 and `cp0_pc`=0x00400100.
  - With `exc_addr_in`=0x00400004 in WAIT: `redirect_pc`=0x00400004 and `pc_redirect` pulses at T+3.
  - `exc_count`=1; `stall` high exactly 3 cycles.
- Eret with `exc_addr_in`=0x00400104: `cp0_eret` and `cp0_exception` pulse; redirect to 0x00400104; `exc_count` unchanged.
- Status=0x0000E020 (bit 0 clear): break issued → no strobe, `busy` stays 0, count unchanged.
- teq with `teq_equal`=0 → ignored. Then teq with `teq_equal`=1 → `cp0_cause`=13.
- Simultaneous flags:
  - `is_mtc0`+`is_syscall`, `rd_in`=12 → `cp0_mtc0`=1, no trap.
  - `is_break`+`is_syscall` → cause 9.
- `rst` asserted in WAIT → next cycle all outputs at reset values. A following syscall sequences normally.
- 256 syscall/eret pairs with `CNT_W`=8 → `exc_count` saturates at 255.
- `exc_addr_in`=0x00000080 on a trap → `vec_err`=1 and stays set.

Source files
------------

// File: rtl/exc_ctrl_if.sv
// Bundle of CPU-execute and CP0-side signals around the exception sequencer.
// The master modport is the CPU/CP0 environment; slave is the sequencer itself.
interface exc_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             instr_valid;
   logic [31:0]      pc_in;
   logic             is_syscall;
   logic             is_break;
   logic             is_teq;
   logic             is_eret;
   logic             teq_equal;
   logic             is_mtc0;
   logic             is_mfc0;
   logic [4:0]       rd_in;
   logic [31:0]      status_in;
   logic [31:0]      exc_addr_in;

   logic             cp0_exception;
   logic             cp0_eret;
   logic [4:0]       cp0_cause;
   logic [31:0]      cp0_pc;
   logic             cp0_mtc0;
   logic             cp0_mfc0;
   logic [4:0]       cp0_rd;
   logic             stall;
   logic             flush;
   logic             pc_redirect;
   logic [31:0]      redirect_pc;
   logic             busy;
   logic [CNT_W-1:0] exc_count;
   logic             vec_err;

   modport master (
      output instr_valid, pc_in, is_syscall, is_break, is_teq, is_eret,
             teq_equal, is_mtc0, is_mfc0, rd_in, status_in, exc_addr_in,
      input  cp0_exception, cp0_eret, cp0_cause, cp0_pc, cp0_mtc0, cp0_mfc0,
             cp0_rd, stall, flush, pc_redirect, redirect_pc, busy, exc_count,
             vec_err
   );

   modport slave (
      input  instr_valid, pc_in, is_syscall, is_break, is_teq, is_eret,
             teq_equal, is_mtc0, is_mfc0, rd_in, status_in, exc_addr_in,
      output cp0_exception, cp0_eret, cp0_cause, cp0_pc, cp0_mtc0, cp0_mfc0,
             cp0_rd, stall, flush, pc_redirect, redirect_pc, busy, exc_count,
             vec_err
   );
endinterface

// File: rtl/exc_ctrl.sv
// Exception sequencer: detects syscall/break/teq/eret, strobes CP0, waits for
// CP0's negedge update, then redirects the PC to exc_addr while stalling the CPU.
module exc_ctrl #(
   parameter logic [31:0] VEC_ADDR = 32'h00400004,
   parameter int          CNT_W    = 8
) (
   input logic       clk,
   input logic       rst,
   exc_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REDIRECT} state_t;

   state_t           state;
   logic             eret_flag;
   logic             exception_q;
   logic             eret_q;
   logic [4:0]       cause_q;
   logic [31:0]      pc_q;
   logic             flush_q;
   logic             redirect_q;
   logic [31:0]      redirect_pc_q;
   logic             busy_q;
   logic [CNT_W-1:0] count_q;
   logic             vec_err_q;

   logic             take;
   logic             sel_eret;
   logic [4:0]       sel_cause;
   logic             idle;
   logic             unused_status;

   assign unused_status = ^{bus.status_in[31:11], bus.status_in[7:1]};
   assign idle          = (state == IDLE);

   // Only the highest-priority flag is considered; if its IM bit is off the
   // whole instruction is ignored rather than falling through to a lower one.
   always_comb begin
      take      = 1'b0;
      sel_eret  = 1'b0;
      sel_cause = 5'd0;
      if (bus.instr_valid && !bus.is_mtc0) begin
         if (bus.is_eret) begin
            take     = 1'b1;
            sel_eret = 1'b1;
         end else if (bus.is_break) begin
            sel_cause = 5'd9;
            take      = bus.status_in[0] & bus.status_in[9];
         end else if (bus.is_syscall) begin
            sel_cause = 5'd8;
            take      = bus.status_in[0] & bus.status_in[8];
         end else if (bus.is_teq && bus.teq_equal) begin
            sel_cause = 5'd13;
            take      = bus.status_in[0] & bus.status_in[10];
         end
      end
   end

   // Strobes default low each cycle so every command is a single-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         eret_flag     <= 1'b0;
         exception_q   <= 1'b0;
         eret_q        <= 1'b0;
         cause_q       <= 5'd0;
         pc_q          <= 32'd0;
         flush_q       <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= 32'd0;
         busy_q        <= 1'b0;
         count_q       <= '0;
         vec_err_q     <= 1'b0;
      end else begin
         exception_q <= 1'b0;
         eret_q      <= 1'b0;
         flush_q     <= 1'b0;
         redirect_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  pc_q        <= bus.pc_in;
                  cause_q     <= sel_cause;
                  eret_flag   <= sel_eret;
                  exception_q <= 1'b1;
                  eret_q      <= sel_eret;
                  busy_q      <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (!eret_flag && count_q != '1) begin
                  count_q <= count_q + CNT_W'(1);
               end
               state <= WAIT;
            end
            // CP0 has updated exc_addr on the negedge inside ISSUE, so it is valid now.
            WAIT: begin
               redirect_pc_q <= bus.exc_addr_in;
               redirect_q    <= 1'b1;
               flush_q       <= 1'b1;
               state         <= REDIRECT;
            end
            REDIRECT: begin
               if (!eret_flag && redirect_pc_q != VEC_ADDR) begin
                  vec_err_q <= 1'b1;
               end
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.cp0_exception = exception_q;
   assign bus.cp0_eret      = eret_q;
   assign bus.cp0_cause     = cause_q;
   assign bus.cp0_pc        = pc_q;
   assign bus.cp0_mtc0      = bus.is_mtc0 & bus.instr_valid & idle;
   assign bus.cp0_mfc0      = bus.is_mfc0 & idle;
   assign bus.cp0_rd        = idle ? bus.rd_in : 5'd0;
   assign bus.stall         = busy_q;
   assign bus.busy          = busy_q;
   assign bus.flush         = flush_q;
   assign bus.pc_redirect   = redirect_q;
   assign bus.redirect_pc   = redirect_pc_q;
   assign bus.exc_count     = count_q;
   assign bus.vec_err       = vec_err_q;
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: drives decode flags after each posedge and
// checks outputs on the following negedge against hand-derived expectations.
module tb_exc_ctrl;
   localparam int          CNT_W = 8;
   localparam logic [31:0] VEC   = 32'h00400004;
   localparam logic [31:0] STALE = 32'hDEADBEEF;

   localparam int K_SYSCALL = 0;
   localparam int K_BREAK   = 1;
   localparam int K_TEQ     = 2;
   localparam int K_ERET    = 3;
   localparam int K_BRKSYS  = 4;
   localparam int K_TEQNE   = 5;

   logic clk;
   logic rst;
   int   testsRun;
   int   failCount;
   int   expCnt;
   logic expVec;

   exc_ctrl_if #(.CNT_W(CNT_W)) bus ();

   exc_ctrl #(.VEC_ADDR(VEC), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] simulation timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int kind, input logic valid, input logic mtc0,
                                input logic mfc0, input logic [4:0] rd,
                                input logic [31:0] pc);
      bus.instr_valid = valid;
      bus.pc_in       = pc;
      bus.is_syscall  = (kind == K_SYSCALL) || (kind == K_BRKSYS);
      bus.is_break    = (kind == K_BREAK) || (kind == K_BRKSYS);
      bus.is_teq      = (kind == K_TEQ) || (kind == K_TEQNE);
      bus.teq_equal   = (kind == K_TEQ);
      bus.is_eret     = (kind == K_ERET);
      bus.is_mtc0     = mtc0;
      bus.is_mfc0     = mfc0;
      bus.rd_in       = rd;
   endtask

   task automatic clearStimulus();
      applyStimulus(-1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".busy"},   32'(bus.busy),          32'd0);
      checkOutput({tag, ".stall"},  32'(bus.stall),         32'd0);
      checkOutput({tag, ".exc"},    32'(bus.cp0_exception), 32'd0);
      checkOutput({tag, ".eret"},   32'(bus.cp0_eret),      32'd0);
      checkOutput({tag, ".cause"},  32'(bus.cp0_cause),     32'd0);
      checkOutput({tag, ".pc"},     bus.cp0_pc,             32'd0);
      checkOutput({tag, ".rpc"},    bus.redirect_pc,        32'd0);
      checkOutput({tag, ".redir"},  32'(bus.pc_redirect),   32'd0);
      checkOutput({tag, ".flush"},  32'(bus.flush),         32'd0);
      checkOutput({tag, ".count"},  32'(bus.exc_count),     32'd0);
      checkOutput({tag, ".vecerr"}, 32'(bus.vec_err),       32'd0);
   endtask

   // Full trap sequence starting and ending at a negedge in IDLE.
   task automatic runSeq(input string tag, input int kind, input logic [31:0] pc,
                         input logic [4:0] expCause, input logic [31:0] excAddr);
      logic isEret;
      isEret = (kind == K_ERET);
      applyStimulus(kind, 1'b1, 1'b0, 1'b0, 5'd0, pc);
      checkOutput({tag, ".stall_det"}, 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      applyStimulus(K_SYSCALL, 1'b1, 1'b1, 1'b1, 5'd12, 32'h0BADF00D);
      bus.exc_addr_in = STALE;
      @(negedge clk);
      checkOutput({tag, ".exc"},    32'(bus.cp0_exception), 32'd1);
      checkOutput({tag, ".eret"},   32'(bus.cp0_eret),      32'(isEret));
      checkOutput({tag, ".cause"},  32'(bus.cp0_cause),     32'(expCause));
      checkOutput({tag, ".pc"},     bus.cp0_pc,             pc);
      checkOutput({tag, ".stall1"}, 32'(bus.stall),         32'd1);
      checkOutput({tag, ".mtc0"},   32'(bus.cp0_mtc0),      32'd0);
      checkOutput({tag, ".mfc0"},   32'(bus.cp0_mfc0),      32'd0);
      @(posedge clk); #1;
      clearStimulus();
      bus.exc_addr_in = excAddr;
      if (!isEret && expCnt < 255) expCnt++;
      @(negedge clk);
      checkOutput({tag, ".exc_w"},  32'(bus.cp0_exception), 32'd0);
      checkOutput({tag, ".stall2"}, 32'(bus.stall),         32'd1);
      checkOutput({tag, ".redir_w"},32'(bus.pc_redirect),   32'd0);
      checkOutput({tag, ".count"},  32'(bus.exc_count),     32'(expCnt));
      @(posedge clk); #1;
      bus.exc_addr_in = STALE;
      @(negedge clk);
      checkOutput({tag, ".redir"},  32'(bus.pc_redirect),   32'd1);
      checkOutput({tag, ".flush"},  32'(bus.flush),         32'd1);
      checkOutput({tag, ".rpc"},    bus.redirect_pc,        excAddr);
      checkOutput({tag, ".stall3"}, 32'(bus.stall),         32'd1);
      checkOutput({tag, ".pc_hold"},bus.cp0_pc,             pc);
      if (!isEret && excAddr != VEC) expVec = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput({tag, ".stall0"}, 32'(bus.stall),         32'd0);
      checkOutput({tag, ".busy0"},  32'(bus.busy),          32'd0);
      checkOutput({tag, ".redir0"}, 32'(bus.pc_redirect),   32'd0);
      checkOutput({tag, ".flush0"}, 32'(bus.flush),         32'd0);
      checkOutput({tag, ".cause_h"},32'(bus.cp0_cause),     32'(expCause));
      checkOutput({tag, ".vecerr"}, 32'(bus.vec_err),       32'(expVec));
   endtask

   // Instruction that must not start a trap.
   task automatic checkIgnored(input string tag, input int kind, input logic mtc0);
      applyStimulus(kind, 1'b1, mtc0, 1'b0, 5'd12, 32'h00400500);
      @(posedge clk); #1;
      clearStimulus();
      @(negedge clk);
      checkOutput({tag, ".busy"},  32'(bus.busy),          32'd0);
      checkOutput({tag, ".exc"},   32'(bus.cp0_exception), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput({tag, ".busy2"}, 32'(bus.busy),          32'd0);
      checkOutput({tag, ".count"}, 32'(bus.exc_count),     32'(expCnt));
   endtask

   initial begin
      testsRun  = 0;
      failCount = 0;
      expCnt    = 0;
      expVec    = 1'b0;
      rst       = 1'b1;
      clearStimulus();
      bus.status_in   = 32'h00000701;
      bus.exc_addr_in = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetValues("reset");
      rst = 1'b0;

      runSeq("syscall", K_SYSCALL, 32'h00400100, 5'd8, 32'h00400004);
      runSeq("eret", K_ERET, 32'h00400200, 5'd0, 32'h00400104);

      bus.status_in = 32'h0000E020;
      checkIgnored("masked_break", K_BREAK, 1'b0);
      runSeq("eret_unmasked", K_ERET, 32'h00400204, 5'd0, 32'h00400108);

      bus.status_in = 32'h00000301;
      checkIgnored("masked_teq_im", K_TEQ, 1'b0);
      bus.status_in = 32'h00000701;
      checkIgnored("teq_ne", K_TEQNE, 1'b0);
      runSeq("teq", K_TEQ, 32'h00400300, 5'd13, 32'h00400004);

      applyStimulus(K_SYSCALL, 1'b1, 1'b1, 1'b0, 5'd12, 32'h00400400);
      #1;
      checkOutput("mtc0_fwd", 32'(bus.cp0_mtc0), 32'd1);
      checkOutput("mtc0_rd",  32'(bus.cp0_rd),   32'd12);
      checkIgnored("mtc0_sys", K_SYSCALL, 1'b1);
      applyStimulus(-1, 1'b0, 1'b0, 1'b1, 5'd14, 32'd0);
      #1;
      checkOutput("mfc0_fwd", 32'(bus.cp0_mfc0), 32'd1);
      checkOutput("mfc0_rd",  32'(bus.cp0_rd),   32'd14);
      clearStimulus();

      runSeq("brk_sys", K_BRKSYS, 32'h00400600, 5'd9, 32'h00400004);

      // Reset in WAIT
      applyStimulus(K_SYSCALL, 1'b1, 1'b0, 1'b0, 5'd0, 32'h00400700);
      @(posedge clk); #1;
      clearStimulus();
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rst_wait.count", 32'(bus.exc_count), 32'(expCnt + 1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      expCnt = 0;
      expVec = 1'b0;
      @(negedge clk);
      checkResetValues("rst_wait");
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rst_wait.nostrobe", 32'(bus.pc_redirect), 32'd0);
      checkOutput("rst_wait.noflush",  32'(bus.flush),       32'd0);
      runSeq("post_rst", K_SYSCALL, 32'h00400800, 5'd8, 32'h00400004);

      for (int i = 0; i < 256; i++) begin
         runSeq("sat_sys", K_SYSCALL, 32'h00401000, 5'd8, 32'h00400004);
         runSeq("sat_eret", K_ERET, 32'h00401004, 5'd0, 32'h00401008);
         if (i == 253) checkOutput("sat_reach", 32'(bus.exc_count), 32'd255);
      end
      checkOutput("sat_final", 32'(bus.exc_count), 32'd255);

      runSeq("vec_bad", K_SYSCALL, 32'h00402000, 5'd8, 32'h00000080);
      checkOutput("vec_set", 32'(bus.vec_err), 32'd1);
      runSeq("vec_sticky", K_SYSCALL, 32'h00402004, 5'd8, 32'h00400004);
      checkOutput("vec_hold", 32'(bus.vec_err), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end
endmodule
